// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable multi-channel clock divider.
// Each channel counts 0..D-1 and drives either a square wave or a one-cycle
// pulse. New divisors are staged as pending and only take effect at the
// channel's period boundary, or immediately while the channel is disabled.
module clk_div_prog #(
    parameter int          NUM_CH      = 4,
    parameter int          DIV_W       = 26,
    parameter int unsigned DEFAULT_DIV = 50000000,
    localparam int         CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [DIV_W-1:0]  wr_div,
    input  logic              wr_mode,
    output logic              wr_ack,
    output logic              wr_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    // One extra bit so NUM_CH itself is representable when NUM_CH is a power of two.
    localparam logic [CH_W:0]    NUM_CH_V  = (CH_W+1)'(NUM_CH);
    localparam logic [DIV_W-1:0] MIN_DIV   = DIV_W'(2);
    localparam logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV);

    logic wr_ok;
    logic wr_ack_reg;
    logic wr_err_reg;

    assign wr_ok  = wr_en && ({1'b0, wr_ch} < NUM_CH_V) && (wr_div >= MIN_DIV);
    assign wr_ack = wr_ack_reg;
    assign wr_err = wr_err_reg;

    // Write handshake: exactly one of ack/err pulses the cycle after a strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ack_reg <= 1'b0;
            wr_err_reg <= 1'b0;
        end else begin
            wr_ack_reg <= wr_ok;
            wr_err_reg <= wr_en && !wr_ok;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DIV_W-1:0] div_reg, div_next;
            logic [DIV_W-1:0] pdiv_reg, pdiv_next;
            logic [DIV_W-1:0] cnt_reg, cnt_next;
            logic [DIV_W-1:0] half_next;
            logic             mode_reg, mode_next;
            logic             pmode_reg, pmode_next;
            logic             pend_reg, pend_next;
            logic             run_reg;
            logic             clk_out_reg, clk_out_next;
            logic             tick_reg, tick_next;
            logic             sel;
            logic             wrap;

            assign sel  = wr_ok && (wr_ch == CH_W'(gi));
            // run_reg marks that the channel was already counting last cycle,
            // so the first enabled cycle presents cnt=0 instead of skipping it.
            assign wrap = run_reg && (cnt_reg == div_reg - 1'b1);

            // Next-state: count/wrap, apply pending at the boundary, stage writes,
            // and precompute outputs so the output flops line up with cnt_reg.
            always_comb begin
                div_next   = div_reg;
                mode_next  = mode_reg;
                pdiv_next  = pdiv_reg;
                pmode_next = pmode_reg;
                pend_next  = pend_reg;
                cnt_next   = cnt_reg;

                if (!en[gi]) begin
                    cnt_next = '0;
                    if (pend_reg) begin
                        div_next  = pdiv_reg;
                        mode_next = pmode_reg;
                        pend_next = 1'b0;
                    end
                end else if (!run_reg) begin
                    cnt_next = '0;
                end else if (wrap) begin
                    cnt_next = '0;
                    if (pend_reg) begin
                        div_next  = pdiv_reg;
                        mode_next = pmode_reg;
                        pend_next = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end

                // A write on the wrap edge lands in pending after the apply above.
                if (sel) begin
                    pdiv_next  = wr_div;
                    pmode_next = wr_mode;
                    pend_next  = 1'b1;
                end

                half_next    = (div_next >> 1) + {{(DIV_W-1){1'b0}}, div_next[0]};
                tick_next    = en[gi] && (cnt_next == div_next - 1'b1);
                clk_out_next = en[gi] && (mode_next ? tick_next : (cnt_next < half_next));
            end

            // Channel state and registered outputs.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    div_reg     <= RESET_DIV;
                    mode_reg    <= 1'b0;
                    pdiv_reg    <= RESET_DIV;
                    pmode_reg   <= 1'b0;
                    pend_reg    <= 1'b0;
                    cnt_reg     <= '0;
                    run_reg     <= 1'b0;
                    clk_out_reg <= 1'b0;
                    tick_reg    <= 1'b0;
                end else begin
                    div_reg     <= div_next;
                    mode_reg    <= mode_next;
                    pdiv_reg    <= pdiv_next;
                    pmode_reg   <= pmode_next;
                    pend_reg    <= pend_next;
                    cnt_reg     <= cnt_next;
                    run_reg     <= en[gi];
                    clk_out_reg <= clk_out_next;
                    tick_reg    <= tick_next;
                end
            end

            assign clk_out[gi] = clk_out_reg;
            assign tick[gi]    = tick_reg;
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog: directed scenarios followed by random traffic,
// checked every cycle against a period-position reference model.
module tb_clk_div_prog;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 8;
    localparam int DEFDIV = 6;
    localparam int CH_W   = 2;

    logic              clk;
    logic              reset;
    logic [NUM_CH-1:0] en;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [DIV_W-1:0]  wr_div;
    logic              wr_mode;
    logic              wr_ack;
    logic              wr_err;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    clk_div_prog #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFDIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
        .wr_mode (wr_mode),
        .wr_ack  (wr_ack),
        .wr_err  (wr_err),
        .clk_out (clk_out),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: where each channel sits inside its period.
    int md   [NUM_CH];   // active period length
    int mm   [NUM_CH];   // active mode
    int mp   [NUM_CH];   // staged period
    int mpm  [NUM_CH];   // staged mode
    int mpend[NUM_CH];
    int mpos [NUM_CH];   // position within current period
    int mrun [NUM_CH];   // channel was enabled at the previous edge
    int exp_ack;
    int exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            md[c] = DEFDIV; mm[c] = 0; mp[c] = DEFDIV; mpm[c] = 0;
            mpend[c] = 0; mpos[c] = 0; mrun[c] = 0;
        end
        exp_ack = 0;
        exp_err = 0;
    endtask

    task automatic model_apply(input int c);
        if (mpend[c] != 0) begin
            md[c] = mp[c]; mm[c] = mpm[c]; mpend[c] = 0;
        end
    endtask

    task automatic model_step();
        bit acc;
        acc = wr_en && (int'(wr_ch) < NUM_CH) && (int'(wr_div) >= 2);
        for (int c = 0; c < NUM_CH; c++) begin
            if (!en[c]) begin
                mpos[c] = 0; mrun[c] = 0; model_apply(c);
            end else if (mrun[c] == 0) begin
                mrun[c] = 1; mpos[c] = 0;
            end else if (mpos[c] == md[c] - 1) begin
                mpos[c] = 0; model_apply(c);
            end else begin
                mpos[c]++;
            end
            if (acc && int'(wr_ch) == c) begin
                mp[c] = int'(wr_div); mpm[c] = int'(wr_mode); mpend[c] = 1;
            end
        end
        exp_ack = acc ? 1 : 0;
        exp_err = (wr_en && !acc) ? 1 : 0;
    endtask

    task automatic check_all();
        logic [NUM_CH-1:0] eo;
        logic [NUM_CH-1:0] et;
        for (int c = 0; c < NUM_CH; c++) begin
            et[c] = (mrun[c] != 0) && (mpos[c] == md[c] - 1);
            // Square wave is high for the first ceil(D/2) positions.
            eo[c] = (mrun[c] != 0) && ((mm[c] != 0) ? et[c] : (2 * mpos[c] < md[c]));
        end
        check("clk_out", 32'(clk_out), 32'(eo));
        check("tick",    32'(tick),    32'(et));
        check("wr_ack",  32'(wr_ack),  32'(exp_ack));
        check("wr_err",  32'(wr_err),  32'(exp_err));
    endtask

    task automatic cyc();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_step();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_write(input int ch, input int div, input int mode);
        wr_en   = 1'b1;
        wr_ch   = CH_W'(ch);
        wr_div  = DIV_W'(div);
        wr_mode = mode[0];
        $display("write ch=%0d div=%0d mode=%0d", ch, div, mode);
        cyc();
        wr_en   = 1'b0;
    endtask

    // Bounded wait for a channel to reach a given period length and position.
    task automatic wait_state(input int ch, input int d, input int pos, input string tag);
        int k;
        k = 0;
        while (!(md[ch] == d && mpos[ch] == pos && mrun[ch] != 0) && k < 600) begin
            cyc();
            k++;
        end
        check(tag, 32'(k < 600), 32'd1);
    endtask

    initial begin
        reset   = 1'b0;
        en      = '0;
        wr_en   = 1'b0;
        wr_ch   = '0;
        wr_div  = '0;
        wr_mode = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();

        // Release reset with all channels running the default divisor.
        reset = 1'b1;
        en    = '1;
        run(10);

        // Basic square, odd square, pulse mode.
        do_write(0, 4, 0);
        run(6);
        do_write(1, 5, 0);
        do_write(2, 3, 1);
        run(30);

        // Mid-period reprogram of ch0.
        do_write(0, 8, 0);
        wait_state(0, 8, 2, "wait_div8");
        do_write(0, 3, 0);
        wait_state(0, 3, 0, "wait_div3");
        run(4);
        do_write(0, 6, 0);
        do_write(0, 10, 0);
        wait_state(0, 10, 0, "wait_div10");
        run(25);

        // Rejected writes: divisor too small, channel out of range.
        do_write(1, 1, 0);
        do_write(1, 0, 1);
        do_write(3, 7, 0);
        run(12);

        // Disabled channel takes a write immediately.
        en[1] = 1'b0;
        run(2);
        do_write(1, 7, 1);
        run(3);
        en[1] = 1'b1;
        run(20);

        // Largest legal divisor.
        do_write(2, 255, 0);
        wait_state(2, 255, 0, "wait_div255");
        run(260);

        // Asynchronous reset at cnt=3 of div=8.
        do_write(0, 8, 0);
        wait_state(0, 8, 3, "wait_rst_pt");
        reset = 1'b0;
        #1;
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick",    32'(tick),    32'd0);
        check("rst_ack",     32'(wr_ack),  32'd0);
        model_reset();
        run(2);
        reset = 1'b1;
        run(15);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            if (i % 25 == 0) en = NUM_CH'($urandom);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_ch   = CH_W'($urandom_range(0, 3));
            wr_div  = DIV_W'($urandom_range(0, 12));
            wr_mode = $urandom_range(0, 1) != 0;
            if (wr_en) $display("write ch=%0d div=%0d mode=%0d", wr_ch, wr_div, wr_mode);
            cyc();
        end
        wr_en = 1'b0;
        run(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
